// File: rtl/melody_piezo_sequencer.sv
// Purpose : plays short fixed melodies (coin, purchase, error, change) on a piezo
//           as square-wave tones separated by silent gaps, selected by a request code.
// Timing  : melody starts one cycle after a valid request; each tone NOTE_MS ms, each gap GAP_MS ms.
// Ports   : clk, rst (async, active high), note_state[3:0] request code (0 = none),
//           note_played[2:0] completed tones, piezo square wave, busy (PLAY/GAP),
//           done one-cycle pulse at end of the last tone.
module melody_piezo_sequencer #(
   parameter int CLK_HZ  = 1_000_000,
   parameter int NOTE_MS = 150,
   parameter int GAP_MS  = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] note_state,
   output logic [2:0] note_played,
   output logic       piezo,
   output logic       busy,
   output logic       done
);

   localparam int MS_DIV = CLK_HZ / 1000;
   localparam int MS_W   = $clog2(MS_DIV + 1);

   // Half-period counts for the tone set; G4 is the lowest pitch and sizes the counter.
   localparam int HP_G4 = CLK_HZ / (2 * 392);
   localparam int HP_C5 = CLK_HZ / (2 * 523);
   localparam int HP_E5 = CLK_HZ / (2 * 659);
   localparam int HP_G5 = CLK_HZ / (2 * 784);
   localparam int HP_C6 = CLK_HZ / (2 * 1047);
   localparam int HP_W  = $clog2(HP_G4 + 1);

   typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_t;

   state_t            state, state_nxt;
   logic [3:0]        code;
   logic [1:0]        idx;
   logic [MS_W-1:0]   ms_cnt;
   logic [15:0]       ms_elapsed;
   logic [HP_W-1:0]   hp_cnt;
   logic [HP_W-1:0]   half;
   logic [2:0]        mel_len;
   logic              req_valid;
   logic              ms_tick;
   logic              last_note;
   logic              load;
   logic              tone_end;
   logic              gap_end;

   assign req_valid = (note_state >= 4'd1) && (note_state <= 4'd4);
   assign busy      = (state == PLAY) || (state == GAP);
   assign ms_tick   = busy && (ms_cnt == MS_W'(MS_DIV - 1));
   assign last_note = ({1'b0, idx} == (mel_len - 3'd1));

   // Melody table: length and half-period of the current note.
   always_comb begin
      mel_len = 3'd0;
      half    = HP_W'(HP_C5);
      case (code)
         4'd1: begin
            mel_len = 3'd2;
            half    = (idx == 2'd0) ? HP_W'(HP_C5) : HP_W'(HP_E5);
         end
         4'd2: begin
            mel_len = 3'd4;
            case (idx)
               2'd0:    half = HP_W'(HP_C5);
               2'd1:    half = HP_W'(HP_E5);
               2'd2:    half = HP_W'(HP_G5);
               default: half = HP_W'(HP_C6);
            endcase
         end
         4'd3: begin
            mel_len = 3'd2;
            half    = HP_W'(HP_G4);
         end
         4'd4: begin
            mel_len = 3'd4;
            case (idx)
               2'd0:    half = HP_W'(HP_C6);
               2'd1:    half = HP_W'(HP_G5);
               2'd2:    half = HP_W'(HP_E5);
               default: half = HP_W'(HP_C5);
            endcase
         end
         default: begin
            mel_len = 3'd0;
            half    = HP_W'(HP_C5);
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Request changes take priority over tone timing while a melody is running.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      tone_end  = 1'b0;
      gap_end   = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               load      = 1'b1;
               state_nxt = PLAY;
            end
         end
         PLAY: begin
            if (!req_valid) begin
               state_nxt = IDLE;
            end else if (note_state != code) begin
               load      = 1'b1;
               state_nxt = PLAY;
            end else if (ms_tick && (ms_elapsed == 16'(NOTE_MS - 1))) begin
               tone_end  = 1'b1;
               state_nxt = last_note ? DONE : GAP;
            end
         end
         GAP: begin
            if (!req_valid) begin
               state_nxt = IDLE;
            end else if (note_state != code) begin
               load      = 1'b1;
               state_nxt = PLAY;
            end else if (ms_tick && (ms_elapsed == 16'(GAP_MS - 1))) begin
               gap_end   = 1'b1;
               state_nxt = PLAY;
            end
         end
         DONE: begin
            if (note_state != code) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         code        <= 4'd0;
         idx         <= 2'd0;
         note_played <= 3'd0;
         done        <= 1'b0;
         ms_cnt      <= '0;
         ms_elapsed  <= 16'd0;
         hp_cnt      <= '0;
         piezo       <= 1'b0;
      end else begin
         done <= 1'b0;

         if (load) begin
            code        <= note_state;
            idx         <= 2'd0;
            note_played <= 3'd0;
         end

         if (tone_end) begin
            if (note_played < mel_len) note_played <= note_played + 3'd1;
            if (last_note) done <= 1'b1;
         end

         if (gap_end) idx <= idx + 2'd1;

         // ms timebase restarts on every entry to PLAY or GAP.
         if (load || tone_end || gap_end) begin
            ms_cnt     <= '0;
            ms_elapsed <= 16'd0;
         end else if (busy) begin
            if (ms_tick) begin
               ms_cnt     <= '0;
               ms_elapsed <= ms_elapsed + 16'd1;
            end else begin
               ms_cnt <= ms_cnt + MS_W'(1);
            end
         end

         // Tone generator runs only while staying in PLAY on the same note;
         // any entry, restart or exit starts it from a low level.
         if ((state == PLAY) && (state_nxt == PLAY) && !load) begin
            if (hp_cnt == half - HP_W'(1)) begin
               hp_cnt <= '0;
               piezo  <= ~piezo;
            end else begin
               hp_cnt <= hp_cnt + HP_W'(1);
            end
         end else begin
            hp_cnt <= '0;
            piezo  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_melody_piezo_sequencer.sv
// Testbench for melody_piezo_sequencer: directed melody scenarios followed by
// randomized request/reset sequences, every cycle compared against a timeline
// model that derives outputs from elapsed time since melody start.
module tb_melody_piezo_sequencer;

   localparam int CLK_HZ  = 100_000;
   localparam int NOTE_MS = 3;
   localparam int GAP_MS  = 1;
   localparam int T_TONE  = NOTE_MS * (CLK_HZ / 1000);
   localparam int T_GAP   = GAP_MS * (CLK_HZ / 1000);
   localparam int T_SLOT  = T_TONE + T_GAP;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   logic       clk;
   logic       rst;
   logic [3:0] note_state;
   logic [2:0] note_played;
   logic       piezo;
   logic       busy;
   logic       done;

   int n_tests;
   int n_fail;

   int m_mode;
   int m_code;
   int m_t;
   int m_np;
   int e_piezo;
   int e_busy;
   int e_done;

   melody_piezo_sequencer #(
      .CLK_HZ (CLK_HZ),
      .NOTE_MS(NOTE_MS),
      .GAP_MS (GAP_MS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .note_state (note_state),
      .note_played(note_played),
      .piezo      (piezo),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   function automatic int mel_len(input int c);
      case (c)
         1, 3:    return 2;
         2, 4:    return 4;
         default: return 0;
      endcase
   endfunction

   // Note k of melody c as a tone frequency, converted to a half-period count.
   function automatic int note_half(input int c, input int k);
      int freq[5];
      int n;
      freq = '{392, 523, 659, 784, 1047};
      case (c)
         1:       n = (k == 0) ? 1 : 2;
         2:       n = 1 + k;
         3:       n = 0;
         default: n = 4 - k;
      endcase
      return CLK_HZ / (2 * freq[n]);
   endfunction

   // Outputs follow from where the melody timeline is: slot k is a tone of
   // T_TONE cycles followed by a gap of T_GAP cycles.
   task automatic model_edge();
      int  k;
      int  off;
      bit  valid;
      valid  = (note_state >= 1) && (note_state <= 4);
      e_done = 0;
      if (rst) begin
         m_mode = M_IDLE;
         m_code = 0;
         m_np   = 0;
      end else begin
         case (m_mode)
            M_IDLE: begin
               if (valid) begin
                  m_mode = M_RUN;
                  m_code = note_state;
                  m_t    = 0;
                  m_np   = 0;
               end
            end
            M_RUN: begin
               if (!valid) begin
                  m_mode = M_IDLE;
               end else if (note_state != m_code) begin
                  m_code = note_state;
                  m_t    = 0;
                  m_np   = 0;
               end else begin
                  m_t = m_t + 1;
                  if (m_t == (mel_len(m_code) - 1) * T_SLOT + T_TONE) begin
                     m_mode = M_DONE;
                     m_np   = mel_len(m_code);
                     e_done = 1;
                  end
               end
            end
            default: begin
               if (note_state != m_code) m_mode = M_IDLE;
            end
         endcase
      end
      e_piezo = 0;
      e_busy  = (m_mode == M_RUN) ? 1 : 0;
      if (m_mode == M_RUN) begin
         k   = m_t / T_SLOT;
         off = m_t % T_SLOT;
         if (off < T_TONE) begin
            e_piezo = (off / note_half(m_code, k)) % 2;
            m_np    = k;
         end else begin
            m_np = k + 1;
         end
      end
   endtask

   task automatic compare_all();
      check("piezo", piezo, e_piezo);
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("note_played", note_played, m_np);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Reset raised between edges must silence the outputs without waiting for a clock.
   task automatic reset_pulse();
      rst = 1'b1;
      #1;
      check("rst_async_piezo", piezo, 0);
      check("rst_async_busy", busy, 0);
      check("rst_async_played", note_played, 0);
      check("rst_async_done", done, 0);
      m_mode = M_IDLE;
      m_code = 0;
      m_np   = 0;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int r;
      n_tests    = 0;
      n_fail     = 0;
      m_mode     = M_IDLE;
      m_code     = 0;
      m_t        = 0;
      m_np       = 0;
      e_piezo    = 0;
      e_busy     = 0;
      e_done     = 0;
      rst        = 1'b1;
      note_state = 4'd0;
      #2;
      check("reset_piezo", piezo, 0);
      check("reset_busy", busy, 0);
      check("reset_played", note_played, 0);
      check("reset_done", done, 0);
      run(3);
      rst = 1'b0;
      run(3);

      // Invalid code in IDLE is ignored.
      note_state = 4'd9;
      run(60);

      // Coin melody held well past its end: exactly one done, no replay.
      note_state = 4'd1;
      run(2 * T_SLOT + 200);
      note_state = 4'd0;
      run(5);

      // Purchase aborted during the first gap.
      note_state = 4'd2;
      run(T_TONE + 50);
      note_state = 4'd0;
      run(5);

      // Change melody replaced by error inside its second tone.
      note_state = 4'd4;
      run(T_SLOT + 100);
      note_state = 4'd3;
      run(2 * T_SLOT + 200);
      note_state = 4'd0;
      run(3);

      // Reset during the third tone of purchase, request still held afterwards.
      note_state = 4'd2;
      run(2 * T_SLOT + 50);
      reset_pulse();
      run(4 * T_SLOT + 100);
      note_state = 4'd0;
      run(3);

      for (int it = 0; it < 30; it++) begin
         r = $urandom_range(0, 99);
         if (r < 10) begin
            reset_pulse();
            run(2);
         end else begin
            if (r < 75) note_state = 4'($urandom_range(1, 4));
            else        note_state = 4'($urandom_range(0, 15));
            run($urandom_range(1, 1200));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/melody_piezo_sequencer.md
MELODY_PIEZO_SEQUENCER -- requirements
Module: melody_piezo_sequencer

Interface
REQ-001 Parameter CLK_HZ, default 1_000_000: system clock frequency in Hz.
REQ-002 Parameter NOTE_MS, default 150: duration of each tone in milliseconds.
REQ-003 Parameter GAP_MS, default 30: silent gap between consecutive tones in milliseconds.
REQ-004 clk  input  1: the single system clock; all state changes occur on its rising edge.
REQ-005 rst  input  1: asynchronous, active-high reset.
REQ-006 note_state  input  4: melody request code from the main control logic; 0 means no request.
REQ-007 note_played  output  3: number of tones of the current melody that have completed.
REQ-008 piezo  output  1: square-wave drive to the piezo buzzer.
REQ-009 busy  output  1: high while a melody is playing (PLAY or GAP state).
REQ-010 done  output  1: one-cycle pulse when the last tone of a melody completes.

Function
REQ-011 The ms tick SHALL be a one-cycle pulse every CLK_HZ/1000 clocks, from a free-running counter cleared on entry to PLAY or GAP.
REQ-012 The melody table SHALL be fixed: 1 = coin {C5,E5}; 2 = purchase {C5,E5,G5,C6}; 3 = error {G4,G4}; 4 = change {C6,G5,E5,C5}; codes 0 and 5-15 = no melody.
REQ-013 Tone half-period counts SHALL equal floor(CLK_HZ/(2*f)): G4 392 Hz, C5 523 Hz, E5 659 Hz, G5 784 Hz, C6 1047 Hz (at 1 MHz: 1275, 956, 758, 637, 477).
REQ-014 The state machine SHALL have the states IDLE, PLAY, GAP and DONE.
REQ-015 IDLE: when note_state is in 1-4, the block SHALL latch the code, set note index 0, clear note_played, and enter PLAY on the next edge; codes 0 and 5-15 keep it in IDLE.
REQ-016 PLAY: piezo SHALL toggle each time the half-period counter reaches count-1, starting at 0 on entry; after NOTE_MS ms ticks the tone ends and note_played increments in that same cycle.
REQ-017 At tone end, if tones remain, the block SHALL enter GAP with piezo held at 0 for GAP_MS ms, then return to PLAY with the next note index.
REQ-018 At the last tone end, the block SHALL pulse done for one cycle, force piezo to 0, and enter DONE.
REQ-019 DONE: the block SHALL hold note_played at the melody length and stay in DONE until note_state differs from the latched code, then go to IDLE. A held request therefore never replays.
REQ-020 In PLAY or GAP, if note_state becomes 0, the block SHALL abort to IDLE next cycle with piezo 0 and note_played held; done is not asserted.
REQ-021 In PLAY or GAP, if note_state changes to a different valid code, the block SHALL restart with the new melody: note index 0, note_played 0, PLAY.
REQ-022 In PLAY or GAP, an invalid code 5-15 SHALL be treated as 0 (abort).
REQ-023 note_played SHALL never exceed the latched melody length and SHALL not wrap.
REQ-024 piezo SHALL be 0 in every state except PLAY.

Reset
REQ-025 While rst is high, the block SHALL force IDLE, piezo=0, note_played=0, busy=0, done=0, and clear all counters and the latched code.
REQ-026 Reset asserted mid-melody SHALL silence piezo immediately (asynchronously); after release the block SHALL start a melody only if note_state holds a valid code.

Verification
REQ-027 note_state=1 held -> busy rises one cycle later; piezo at 523 Hz for 150 ms, 30 ms silence, 659 Hz for 150 ms; note_played 0->1->2; one done pulse at 330 ms; no replay while note_state stays 1.
REQ-028 note_state=2 -> note_played steps 1,2,3,4 at 150, 330, 510, 690 ms; measured piezo half-periods 956, 758, 637, 477 clocks.
REQ-029 note_state=4 started, then changed to 3 at 200 ms (inside the second tone) -> note_played drops to 0; two G4 tones play (half-period 1275); done fires once at 200+330 ms.
REQ-030 note_state=2 started, then dropped to 0 during the first gap -> IDLE next cycle, piezo 0, note_played stays 1, no done pulse.
REQ-031 rst pulsed during the third tone of melody 2 -> piezo 0 within the reset cycle and all outputs at reset values; after release with note_state=2 still held, the melody restarts from note_played=0.
REQ-032 note_state=9 applied in IDLE -> no state change; piezo, busy and note_played stay 0.
